// File: rtl/cpu_pkg.sv
// Shared datapath definitions: data width and the clear-sweep state encoding.
package cpu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file: range check, entry-0
// masking and same-cycle write forwarding.
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic [AW-1:0]    raddr,
    input  logic             wr_ok,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic in_range_s;

    // Select storage, forwarded write data or zero for this port.
    always_comb begin
        rdata      = '0;
        in_range_s = ({1'b0, raddr} < DEPTH_W);
        if (!in_range_s) begin
            rdata = '0;
        end else if ((ZERO_R0 != 0) && (raddr == '0)) begin
            rdata = '0;
        end else if ((BYPASS != 0) && wr_ok && (raddr == waddr)) begin
            rdata = wdata;
        end else begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/reg_file_sweep.sv
// Multi-entry register file with one write port, two read ports and a
// one-entry-per-cycle clear sweep that blocks writes while it runs.
module reg_file_sweep
    import cpu_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int DEPTH   = 8,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy
);

    localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];
    localparam int            LAST_I  = DEPTH - 1;
    localparam logic [AW-1:0] LAST    = LAST_I[AW-1:0];

    logic [WIDTH-1:0] mem_r [DEPTH];
    clr_state_e       state_r;
    clr_state_e       state_nx_s;
    logic [AW-1:0]    cnt_r;
    logic [AW-1:0]    cnt_nx_s;
    logic             busy_r;
    logic             wr_ok_s;

    // A write commits only when idle, in range and not aimed at a hard-wired zero entry.
    always_comb begin
        wr_ok_s = we && !busy_r && ({1'b0, waddr} < DEPTH_W)
                  && !((ZERO_R0 != 0) && (waddr == '0));
    end

    // Clear-sweep next-state and counter logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nx_s = ST_CLEAR;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == LAST) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + AW'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State, counter and registered busy flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            busy_r  <= (state_nx_s == ST_CLEAR);
        end
    end

    // Storage: reset clears everything, the sweep clears one entry per cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (state_r == ST_CLEAR) begin
            mem_r[cnt_r] <= '0;
        end else if (wr_ok_s) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign busy = busy_r;

    rf_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
    ) u_port_a (
        .mem(mem_r), .raddr(raddr_a), .wr_ok(wr_ok_s),
        .waddr(waddr), .wdata(wdata), .rdata(rdata_a)
    );

    rf_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
    ) u_port_b (
        .mem(mem_r), .raddr(raddr_b), .wr_ok(wr_ok_s),
        .waddr(waddr), .wdata(wdata), .rdata(rdata_b)
    );

endmodule
